// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM-to-stream reader.
// Holds the FSM state encoding and the skid-buffer depth.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FifoDepth = 2;
    localparam int FifoPtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int FifoCntW  = $clog2(FifoDepth + 1);

    // Pointer increment that wraps at FifoDepth, so non-power-of-two depths also work.
    function automatic logic [FifoPtrW-1:0] ptr_inc(input logic [FifoPtrW-1:0] p);
        if (p == FifoPtrW'(FifoDepth - 1)) begin
            return '0;
        end
        return p + FifoPtrW'(1);
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// RAM port and downstream stream bundle of the RAM-to-stream reader.
// master = the reader; slave = RAM model plus stream consumer.
interface ram_stream_reader_if #(
    parameter int Width = 32
);
    // RAM port: rdata_i is valid exactly one cycle after req_o.
    // Stream: a beat moves when m_valid_o and m_ready_i are both high; m_data_o
    // holds steady while m_valid_o is high and m_ready_i is low.
    logic                 req_o;
    logic                 write_o;
    logic [31:0]          addr_o;
    logic [Width-1:0]     wdata_o;
    logic [Width/8-1:0]   wmask_o;
    logic [Width-1:0]     rdata_i;
    logic                 m_valid_o;
    logic [Width-1:0]     m_data_o;
    logic                 m_ready_i;

    modport master (
        output req_o, write_o, addr_o, wdata_o, wmask_o, m_valid_o, m_data_o,
        input  rdata_i, m_ready_i
    );

    modport slave (
        input  req_o, write_o, addr_o, wdata_o, wmask_o, m_valid_o, m_data_o,
        output rdata_i, m_ready_i
    );

endinterface

// File: rtl/ram_stream_reader_fifo.sv
// Small FIFO buffering RAM read data ahead of the output stream.
// Head word is presented combinationally; push and pop may coincide.
module ram_stream_reader_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [Width-1:0]    data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [FifoCntW-1:0] count_o
);

    logic [Width-1:0]    mem_q [FifoDepth];
    logic [FifoPtrW-1:0] wr_ptr_q;
    logic [FifoPtrW-1:0] rd_ptr_q;
    logic [FifoCntW-1:0] count_q;
    logic [FifoCntW-1:0] count_d;
    logic                do_push;
    logic                do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FifoCntW'(FifoDepth));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q + FifoCntW'(do_push) - FifoCntW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads len_i consecutive RAM words from base_addr_i and streams them out in order.
// Optional XOR checksum output csum_o when RAM_STREAM_READER_CSUM_EN is defined.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int Width = 32,
    parameter int LenW  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [31:0]         base_addr_i,
    input  logic [LenW-1:0]     len_i,
    output logic                busy_o,
    output logic                done_o,
`ifdef RAM_STREAM_READER_CSUM_EN
    output logic [Width-1:0]    csum_o,
`endif
    output state_e              dbg_state_o,
    ram_stream_reader_if.master bus
);

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [LenW-1:0]     cnt_q, cnt_d;
    logic                inflight_q;
    logic                zero_done_q, zero_done_d;
    logic                req;
    logic                done_drain;
    logic                beat;
    logic                credit_ok;
    logic                fifo_empty;
    logic                fifo_full;
    logic [FifoCntW-1:0] fifo_count;
    logic [FifoCntW:0]   load;
    logic [Width-1:0]    fifo_data;

    assign beat = !fifo_empty && bus.m_ready_i;

    // Occupancy is counted after this cycle's pop, so a drained slot can be
    // refilled immediately and a ready consumer sees one beat per cycle.
    assign load      = {1'b0, fifo_count} + (FifoCntW + 1)'(inflight_q) - (FifoCntW + 1)'(beat);
    assign credit_ok = (load < (FifoCntW + 1)'(FifoDepth)) && !(fifo_full && !beat);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        zero_done_d = 1'b0;
        req         = 1'b0;
        done_drain  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        addr_d  = base_addr_i;
                        cnt_d   = len_i;
                    end
                end
            end
            ST_RUN: begin
                if (credit_ok) begin
                    req    = 1'b1;
                    addr_d = addr_q + 32'd1;
                    cnt_d  = cnt_q - LenW'(1);
                    if (cnt_q == LenW'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    done_drain = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            inflight_q  <= req;
            zero_done_q <= zero_done_d;
        end
    end

    ram_stream_reader_fifo #(
        .Width (Width)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (inflight_q),
        .data_i  (bus.rdata_i),
        .pop_i   (beat),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef RAM_STREAM_READER_CSUM_EN
    logic             start_acc;
    logic [Width-1:0] csum_q, csum_d;

    assign start_acc = (state_q == ST_IDLE) && start_i;

    always_comb begin
        csum_d = csum_q;
        if (start_acc) begin
            csum_d = '0;
        end else if (beat) begin
            csum_d = csum_q ^ fifo_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;
`endif

    assign bus.req_o     = req;
    assign bus.write_o   = 1'b0;
    assign bus.addr_o    = addr_q;
    assign bus.wdata_o   = '0;
    assign bus.wmask_o   = '0;
    assign bus.m_valid_o = !fifo_empty;
    assign bus.m_data_o  = fifo_data;

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_drain || zero_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: RAM model, stimulus driver, and a
// scoreboard monitor comparing stream beats and request addresses against queues.
module tb_ram_stream_reader;
  import ram_stream_reader_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  state_e      dbg_state;
`ifdef RAM_STREAM_READER_CSUM_EN
  logic [31:0] csum_o;
`endif

  ram_stream_reader_if #(.Width(32)) bus_if ();

  ram_stream_reader #(.Width(32), .LenW(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
`ifdef RAM_STREAM_READER_CSUM_EN
    .csum_o      (csum_o),
`endif
    .dbg_state_o (dbg_state),
    .bus         (bus_if)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  logic [31:0] ram_mem [logic [31:0]];

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (bus_if.req_o) bus_if.rdata_i <= ram_word(bus_if.addr_o);
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] addr_exp_q[$];
  int          beat_cyc_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          beats_seen = 0;
  int          reqs_seen = 0;
  int          done_cnt = 0;
  bit          addr_chk_en = 1'b1;
  int          start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", bus_if.m_valid_o, 1);
        check("hold_data", bus_if.m_data_o, prev_data);
      end
      if (bus_if.m_valid_o && bus_if.m_ready_i) begin
        beat_cyc_q.push_back(cyc);
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%08h expected none", bus_if.m_data_o);
        end else begin
          check("beat_data", bus_if.m_data_o, exp_q.pop_front());
        end
      end
      if (bus_if.req_o) begin
        reqs_seen++;
        check("write_tied", bus_if.write_o, 0);
        check("wdata_tied", bus_if.wdata_o, 0);
        check("wmask_tied", bus_if.wmask_o, 0);
        if (addr_chk_en) begin
          if (addr_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: got addr 0x%08h expected none", bus_if.addr_o);
          end else begin
            check("req_addr", bus_if.addr_o, addr_exp_q.pop_front());
          end
        end
      end
      if (done_o) done_cnt++;
      prev_stall = bus_if.m_valid_o && !bus_if.m_ready_i;
      prev_data  = bus_if.m_data_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [15:0] len);
    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = len;
    step(1);
    start_i   = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name, output int at_cyc);
    bit seen;
    seen   = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done_o) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end else begin
        step(1);
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got no done_o expected done_o within 60 cycles", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int at;
    int d0;
    int r0;
    int b0;
    int guard;

    rst_ni           = 1'b0;
    start_i          = 1'b0;
    base_addr_i      = '0;
    len_i            = '0;
    bus_if.m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) ram_mem[32'h10 + i] = 32'hA0 + i;
    ram_mem[32'h40] = 32'h1;
    ram_mem[32'h41] = 32'h2;
    ram_mem[32'h42] = 32'h4;
    ram_mem[32'h43] = 32'h8;

    step(3);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_req", bus_if.req_o, 0);
    check("rst_valid", bus_if.m_valid_o, 0);
    check("rst_addr", bus_if.addr_o, 0);
    check("rst_mdata", bus_if.m_data_o, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_ni = 1'b1;
    step(2);

    // T1: four words, consumer always ready
    beat_cyc_q.delete();
    d0 = done_cnt;
    r0 = reqs_seen;
    exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
    exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
    addr_exp_q.push_back(32'h10); addr_exp_q.push_back(32'h11);
    addr_exp_q.push_back(32'h12); addr_exp_q.push_back(32'h13);
    start_xfer(32'h10, 16'd4);
    check("t1_busy", busy_o, 1);
    wait_done("t1", at);
    check("t1_done_cyc", at, start_cyc + 6);
    check("t1_busy_in_done", busy_o, 1);
    step(1);
    check("t1_busy_after", busy_o, 0);
    check("t1_done_after", done_o, 0);
    check("t1_nbeats", beat_cyc_q.size(), 4);
    for (int i = 0; i < 4 && i < beat_cyc_q.size(); i++)
      check("t1_beat_cyc", beat_cyc_q[i], start_cyc + 2 + i);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_nreqs", reqs_seen - r0, 4);

    // T2: same words, consumer stalls for cycles 3..6 after start
    step(2);
    d0 = done_cnt;
    exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
    exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
    addr_exp_q.push_back(32'h10); addr_exp_q.push_back(32'h11);
    addr_exp_q.push_back(32'h12); addr_exp_q.push_back(32'h13);
    start_xfer(32'h10, 16'd4);
    for (int r = 1; r <= 8; r++) begin
      step(1);
      bus_if.m_ready_i = !(r >= 3 && r <= 6);
      if (r == 5) begin
        #2;
        check("t2_req_stalled", bus_if.req_o, 0);
        check("t2_valid_stalled", bus_if.m_valid_o, 1);
      end
    end
    bus_if.m_ready_i = 1'b1;
    wait_done("t2", at);
    check("t2_done_cyc", at, start_cyc + 10);
    step(1);
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_exp_empty", exp_q.size(), 0);

    // T3: zero length
    step(2);
    d0 = done_cnt;
    r0 = reqs_seen;
    start_xfer(32'h10, 16'd0);
    check("t3_done", done_o, 1);
    check("t3_busy", busy_o, 0);
    step(1);
    check("t3_done_pulse", done_o, 0);
    check("t3_busy_after", busy_o, 0);
    step(3);
    check("t3_nreqs", reqs_seen - r0, 0);
    check("t3_done_once", done_cnt - d0, 1);

    // T4: address wrap at 2^32
    d0 = done_cnt;
    exp_q.push_back(32'hA5A5_FFFE); exp_q.push_back(32'hA5A5_FFFF);
    exp_q.push_back(32'h5A5A_0000); exp_q.push_back(32'h5A5A_0001);
    addr_exp_q.push_back(32'hFFFF_FFFE); addr_exp_q.push_back(32'hFFFF_FFFF);
    addr_exp_q.push_back(32'h0000_0000); addr_exp_q.push_back(32'h0000_0001);
    start_xfer(32'hFFFF_FFFE, 16'd4);
    wait_done("t4", at);
    step(1);
    check("t4_done_once", done_cnt - d0, 1);
    check("t4_addr_empty", addr_exp_q.size(), 0);

    // T5: reset after the second beat of an eight-word transfer
    step(2);
    d0 = done_cnt;
    b0 = beats_seen;
    addr_chk_en = 1'b0;
    exp_q.push_back(32'h5A5A_0100); exp_q.push_back(32'h5A5A_0101);
    start_xfer(32'h100, 16'd8);
    guard = 0;
    while (beats_seen - b0 < 2 && guard < 20) begin
      step(1);
      guard++;
    end
    check("t5_two_beats", beats_seen - b0, 2);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_done", done_o, 0);
    check("t5_rst_req", bus_if.req_o, 0);
    check("t5_rst_valid", bus_if.m_valid_o, 0);
    check("t5_rst_addr", bus_if.addr_o, 0);
    check("t5_rst_mdata", bus_if.m_data_o, 0);
    step(1);
    rst_ni = 1'b1;
    addr_exp_q.delete();
    addr_chk_en = 1'b1;
    r0 = reqs_seen;
    step(10);
    check("t5_no_beats", beats_seen - b0, 2);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_no_reqs", reqs_seen - r0, 0);
    check("t5_idle", busy_o, 0);

    // T6: normal run after reset; a start while busy is ignored
    d0 = done_cnt;
    b0 = beats_seen;
    exp_q.push_back(32'h5A5A_0020); exp_q.push_back(32'h5A5A_0021);
    exp_q.push_back(32'h5A5A_0022);
    addr_exp_q.push_back(32'h20); addr_exp_q.push_back(32'h21);
    addr_exp_q.push_back(32'h22);
    start_xfer(32'h20, 16'd3);
    start_i     = 1'b1;
    base_addr_i = 32'h80;
    len_i       = 16'd5;
    step(1);
    start_i = 1'b0;
    wait_done("t6", at);
    check("t6_done_cyc", at, start_cyc + 5);
    step(8);
    check("t6_nbeats", beats_seen - b0, 3);
    check("t6_done_once", done_cnt - d0, 1);
    check("t6_idle", busy_o, 0);

`ifdef RAM_STREAM_READER_CSUM_EN
    // T7: checksum of 1,2,4,8
    exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    addr_exp_q.push_back(32'h40); addr_exp_q.push_back(32'h41);
    addr_exp_q.push_back(32'h42); addr_exp_q.push_back(32'h43);
    start_xfer(32'h40, 16'd4);
    check("t7_csum_clear", csum_o, 0);
    wait_done("t7", at);
    check("t7_csum_done", csum_o, 32'hF);
    step(2);
    check("t7_csum_held", csum_o, 32'hF);
`endif

    check("end_exp_empty", exp_q.size(), 0);
    check("end_addr_empty", addr_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001: Parameter Width SHALL default 32; data word width, identical to the RAM port width.
REQ-002: Parameter LenW SHALL default 16; width of the transfer length field.
REQ-003: clk_i  input  1  single clock; all logic SHALL be rising-edge on clk_i.
REQ-004: rst_ni  input  1  reset, asynchronous, active-low.
REQ-005: start_i  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006: base_addr_i  input  32  first RAM word address; captured on accepted start.
REQ-007: len_i  input  LenW  number of words to read; captured on accepted start.
REQ-008: busy_o  output  1  high from accepted start until the cycle done_o pulses, inclusive.
REQ-009: done_o  output  1  one-cycle pulse after the last word is accepted downstream.
REQ-010: req_o / write_o / addr_o  output  1/1/32  RAM port request; write_o SHALL be tied 0.
REQ-011: wdata_o / wmask_o  output  Width/Width/8  SHALL be tied to 0.
REQ-012: rdata_i  input  Width  RAM read data, valid exactly one cycle after req_o.
REQ-013: m_valid_o / m_data_o / m_ready_i  out/out/in  1/Width/1  downstream stream; a beat transfers when valid and ready are both high.

Function
REQ-014: States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start_i with len_i!=0; RUN->DRAIN after the final request issues; DRAIN->IDLE when the buffer is empty and no read is in flight, with done_o pulsed in the same cycle.
REQ-015: start_i with len_i==0 SHALL pulse done_o on the next cycle, issue no request, and stay in IDLE.
REQ-016: start_i while busy_o is high SHALL be ignored without side effects.
REQ-017: In RUN, req_o SHALL assert only when (buffer occupancy + reads in flight) < 2.
REQ-018: The n-th request SHALL present addr_o = base + n (word addressing), wrapping modulo 2^32.
REQ-019: rdata_i SHALL be written into a 2-entry FIFO on the cycle after each req_o; reads in flight SHALL never exceed 1.
REQ-020: m_valid_o SHALL equal FIFO non-empty; m_data_o SHALL be the FIFO head; order SHALL match address order.
REQ-021: With m_ready_i held high, the block SHALL sustain one beat per cycle after a first-beat latency of 2 cycles from start_i.
REQ-022: m_data_o SHALL remain stable while m_valid_o is high and m_ready_i is low.
REQ-023: A FIFO push and pop in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-024: On rst_ni low: state IDLE; busy_o, done_o, req_o, m_valid_o = 0; addr_o, m_data_o = 0; FIFO emptied; in-flight flag cleared.
REQ-025: Reset asserted mid-transfer SHALL abort it; no done_o SHALL follow, and no beat SHALL be output after release.

Configuration
REQ-026: With macro RAM_STREAM_READER_CSUM_EN defined, the block SHALL add output csum_o [Width-1:0], which clears on accepted start and XOR-accumulates every transferred beat; it SHALL be final in the done_o cycle and held until the next start.
REQ-027: Without RAM_STREAM_READER_CSUM_EN, csum_o and its logic SHALL be absent.

Structure
REQ-028: Package ram_stream_reader_pkg SHALL hold the state enum type and the constant FIFO depth (2).
REQ-029: The 2-entry buffer SHALL be sub-module ram_stream_reader_fifo (Width parameter, push/pop/full/empty, async active-low reset).

Verification
REQ-030: RAM[0x10..0x13]=A0..A3, start base=0x10 len=4, ready=1 -> beats A0,A1,A2,A3 on consecutive cycles, first 2 cycles after start, done_o pulses once.
REQ-031: Same stimulus, ready low cycles 3-6 -> req_o stalls at occupancy 2, no lost/duplicated beats, data held stable.
REQ-032: start len=0 -> done_o pulses the next cycle, req_o never asserts, busy_o stays 0.
REQ-033: base=0xFFFF_FFFE len=4 -> addr_o sequence FFFF_FFFE, FFFF_FFFF, 0, 1.
REQ-034: rst_ni low for 1 cycle after the 2nd beat of an 8-word transfer -> all outputs 0, no further beats, no done_o; a new start then runs normally.
REQ-035 (CSUM_EN): words 0x1,0x2,0x4,0x8 -> csum_o=0xF in the done_o cycle.
